// File: rtl/dcache_wb_burst_if.sv
// dcache_wb_burst_if: LSU-side request/response and memory burst port of the data cache.
interface dcache_wb_burst_if;
    logic        cpu_req_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_wdata_i;
    logic [31:0] cpu_rdata_o;
    logic        cpu_rvalid_o;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ready_i;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ready_i,
        output cpu_rdata_o, cpu_rvalid_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ready_i,
        input  cpu_rdata_o, cpu_rvalid_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/dcache_wb_burst.sv
// dcache_wb_burst: direct-mapped write-back/write-allocate data cache with burst writeback and refill.
// Performance counters are built only when DCACHE_PERF_CNT_EN is defined.
module dcache_wb_burst #(
    parameter int NUM_LINES      = 4,
    parameter int WORDS_PER_LINE = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    dcache_wb_burst_if.slave   bus,
    output logic [31:0]        acc_cnt_o,
    output logic [31:0]        hit_cnt_o,
    output logic [31:0]        miss_cnt_o
);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, REFILL} state_t;

    state_t               state, state_n;
    logic [TAG_W-1:0]     req_tag;
    logic [IDX_W-1:0]     req_idx;
    logic [OFF_W-1:0]     req_word;
    logic [OFF_W-1:0]     beat;
    logic [31:0]          req_wdata;
    logic                 req_we;
    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [31:0]          data_mem [NUM_LINES][WORDS_PER_LINE];
    logic                 hit;
    logic                 capture;
    logic                 beat_done;
    logic                 last_beat;
    logic                 unused_addr_lsb;

    assign unused_addr_lsb = ^bus.cpu_addr_i[1:0];
    assign capture   = state == IDLE && bus.cpu_req_i;
    assign hit       = valid[req_idx] && tag_mem[req_idx] == req_tag;
    assign beat_done = bus.mem_ready_i && (state == WRITEBACK || state == REFILL);
    assign last_beat = &beat;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = bus.cpu_req_i ? COMPARE : IDLE;
            COMPARE:   state_n = hit ? IDLE : (valid[req_idx] && dirty[req_idx]) ? WRITEBACK : REFILL;
            WRITEBACK: state_n = (bus.mem_ready_i && last_beat) ? REFILL : WRITEBACK;
            REFILL:    state_n = (bus.mem_ready_i && last_beat) ? COMPARE : REFILL;
            default:   state_n = IDLE;
        endcase
    end

    assign bus.cpu_rvalid_o = state == COMPARE && hit;
    assign bus.cpu_rdata_o  = (state == COMPARE && hit) ? data_mem[req_idx][req_word] : '0;
    assign bus.stall_o      = !(state == IDLE || (state == COMPARE && hit));
    assign bus.mem_req_o    = state == WRITEBACK || state == REFILL;
    assign bus.mem_we_o     = state == WRITEBACK;
    assign bus.mem_addr_o   = state == WRITEBACK ? {tag_mem[req_idx], req_idx, beat, 2'b00} :
                              state == REFILL    ? {req_tag, req_idx, beat, 2'b00} : '0;
    assign bus.mem_wdata_o  = state == WRITEBACK ? data_mem[req_idx][beat] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_tag   <= '0;
            req_idx   <= '0;
            req_word  <= '0;
            req_wdata <= '0;
            req_we    <= 1'b0;
            beat      <= '0;
            valid     <= '0;
            dirty     <= '0;
        end else begin
            if (capture) begin
                {req_tag, req_idx, req_word} <= bus.cpu_addr_i[31:2];
                req_wdata <= bus.cpu_wdata_i;
                req_we    <= bus.cpu_we_i;
            end
            if (state == COMPARE) beat <= '0;
            else if (beat_done)   beat <= beat + OFF_W'(1);
            if (state == COMPARE && hit && req_we) dirty[req_idx] <= 1'b1;
            if (state == REFILL && bus.mem_ready_i && last_beat) begin
                valid[req_idx] <= 1'b1;
                dirty[req_idx] <= 1'b0;
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits guard their contents.
    always_ff @(posedge clk_i) begin
        if (state == COMPARE && hit && req_we) data_mem[req_idx][req_word] <= req_wdata;
        if (state == REFILL && bus.mem_ready_i) data_mem[req_idx][beat] <= bus.mem_rdata_i;
        if (state == REFILL && bus.mem_ready_i && last_beat) tag_mem[req_idx] <= req_tag;
    end

`ifdef DCACHE_PERF_CNT_EN
    logic first_cmp;

    // Only the first compare of a request counts; the post-refill re-compare does not.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            first_cmp  <= 1'b0;
            acc_cnt_o  <= '0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            if (capture)               first_cmp <= 1'b1;
            else if (state == COMPARE) first_cmp <= 1'b0;
            if (state == COMPARE && first_cmp) begin
                acc_cnt_o <= acc_cnt_o + 32'd1;
                if (hit) hit_cnt_o  <= hit_cnt_o + 32'd1;
                else     miss_cnt_o <= miss_cnt_o + 32'd1;
            end
        end
    end
`else
    assign acc_cnt_o  = '0;
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif
endmodule

// File: tb/tb_dcache_wb_burst.sv
// tb_dcache_wb_burst: directed scoreboard bench for dcache_wb_burst with a reference cache and memory model.
module tb_dcache_wb_burst;
    localparam int NL  = 4;
    localparam int WPL = 8;
    localparam int OFF = $clog2(WPL);
    localparam int IDX = $clog2(NL);

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
    } beat_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] acc_cnt_o, hit_cnt_o, miss_cnt_o;
    int          checks = 0;
    int          failures = 0;

    beat_t       beat_q[$];
    logic [31:0] rsp_q[$];
    logic [31:0] mem_wr[logic [31:0]];
    logic        m_valid[NL];
    logic        m_dirty[NL];
    logic [31:0] m_tag[NL];
    logic [31:0] m_data[NL][WPL];
    int          m_acc, m_hit, m_miss;

    dcache_wb_burst_if bus();

    dcache_wb_burst #(.NUM_LINES(NL), .WORDS_PER_LINE(WPL)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .bus        (bus.slave),
        .acc_cnt_o  (acc_cnt_o),
        .hit_cnt_o  (hit_cnt_o),
        .miss_cnt_o (miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_wr.exists(a) ? mem_wr[a] : ((a * 32'd3) ^ 32'h1357_9BDF);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_acc = 0;
        m_hit = 0;
        m_miss = 0;
        beat_q.delete();
        rsp_q.delete();
    endtask

    task automatic check_counters();
`ifdef DCACHE_PERF_CNT_EN
        check("acc_cnt", acc_cnt_o, m_acc);
        check("hit_cnt", hit_cnt_o, m_hit);
        check("miss_cnt", miss_cnt_o, m_miss);
`else
        check("acc_cnt", acc_cnt_o, 32'd0);
        check("hit_cnt", hit_cnt_o, 32'd0);
        check("miss_cnt", miss_cnt_o, 32'd0);
`endif
    endtask

    // Reference model: pushes the expected memory beats and load data for one access.
    task automatic predict(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int          idx  = int'((addr >> (2 + OFF)) % NL);
        int          word = int'((addr >> 2) % WPL);
        logic [31:0] tag  = addr >> (2 + OFF + IDX);
        logic [31:0] a;
        m_acc++;
        if (m_valid[idx] && m_tag[idx] == tag) m_hit++;
        else begin
            m_miss++;
            if (m_valid[idx] && m_dirty[idx])
                for (int b = 0; b < WPL; b++) begin
                    a = (m_tag[idx] << (2 + OFF + IDX)) | (32'(idx) << (2 + OFF)) | (32'(b) << 2);
                    beat_q.push_back('{addr: a, we: 1'b1, data: m_data[idx][b]});
                    mem_wr[a] = m_data[idx][b];
                end
            for (int b = 0; b < WPL; b++) begin
                a = (tag << (2 + OFF + IDX)) | (32'(idx) << (2 + OFF)) | (32'(b) << 2);
                beat_q.push_back('{addr: a, we: 1'b0, data: 32'h0});
                m_data[idx][b] = mem_rd(a);
            end
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tag;
        end
        if (we) begin
            m_data[idx][word] = wdata;
            m_dirty[idx] = 1'b1;
        end else rsp_q.push_back(m_data[idx][word]);
    endtask

    // Drives one request, acts as main memory, and scores every beat and the completion.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int hold_beat, input int hold_len, input int abort_beat,
                          output int lat, output logic [31:0] rdata);
        beat_t b;
        int    refill_n = 0;
        int    held = 0;
        bit    done = 0;
        bit    aborted = 0;
        bit    pending;
        predict(we, addr, wdata);
        lat = -1;
        rdata = '0;
        @(negedge clk_i);
        bus.cpu_req_i   = 1'b1;
        bus.cpu_we_i    = we;
        bus.cpu_addr_i  = addr;
        bus.cpu_wdata_i = wdata;
        for (int n = 1; n <= 400 && !done; n++) begin
            @(negedge clk_i);
            bus.mem_ready_i = 1'b0;
            if (bus.cpu_rvalid_o) begin
                lat   = n;
                rdata = bus.cpu_rdata_o;
                check("stall_at_done", bus.stall_o, 1'b0);
                check("mem_req_at_done", bus.mem_req_o, 1'b0);
                check("mem_addr_idle", bus.mem_addr_o, 32'h0);
                check("mem_wdata_idle", bus.mem_wdata_o, 32'h0);
                if (!we) check("load_data", bus.cpu_rdata_o, rsp_q.pop_front());
                bus.cpu_req_i = 1'b0;
                done = 1;
            end else begin
                check("stall_busy", bus.stall_o, 1'b1);
                if (bus.mem_req_o) begin
                    pending = beat_q.size() != 0;
                    check("beat_expected", pending, 1'b1);
                    if (pending) begin
                        b = beat_q[0];
                        check("mem_addr", bus.mem_addr_o, b.addr);
                        check("mem_we", bus.mem_we_o, b.we);
                        if (b.we) check("mem_wdata", bus.mem_wdata_o, b.data);
                        if (!b.we && refill_n == abort_beat) begin
                            rst_ni = 1'b0;
                            #1;
                            check("rst_mem_req", bus.mem_req_o, 1'b0);
                            check("rst_stall", bus.stall_o, 1'b0);
                            check("rst_mem_addr", bus.mem_addr_o, 32'h0);
                            check("rst_acc", acc_cnt_o, 32'h0);
                            check("rst_miss", miss_cnt_o, 32'h0);
                            bus.cpu_req_i = 1'b0;
                            model_reset();
                            @(negedge clk_i);
                            rst_ni = 1'b1;
                            done = 1;
                            aborted = 1;
                        end else if (!b.we && refill_n == hold_beat && held < hold_len) begin
                            held++;
                        end else begin
                            bus.mem_ready_i = 1'b1;
                            bus.mem_rdata_i = b.we ? 32'h0 : mem_rd(b.addr);
                            void'(beat_q.pop_front());
                            if (!b.we) refill_n++;
                        end
                    end
                end
            end
        end
        check("completed_in_budget", done, 1'b1);
        if (!aborted) begin
            check("beats_all_seen", beat_q.size(), 32'd0);
            check_counters();
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        bus.cpu_req_i   = 1'b0;
        bus.cpu_we_i    = 1'b0;
        bus.cpu_addr_i  = '0;
        bus.cpu_wdata_i = '0;
        bus.mem_rdata_i = '0;
        bus.mem_ready_i = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_i);
        check("reset_stall", bus.stall_o, 1'b0);
        check("reset_rvalid", bus.cpu_rvalid_o, 1'b0);
        check("reset_mem_req", bus.mem_req_o, 1'b0);
        check("reset_mem_addr", bus.mem_addr_o, 32'h0);
        check("reset_mem_we", bus.mem_we_o, 1'b0);
        check_counters();
        rst_ni = 1'b1;

        access(1'b0, 32'h40, 32'h0, -1, 0, -1, lat, rd);
        check("clean_miss_latency", lat, 32'd10);
        check("clean_miss_data", rd, mem_rd(32'h40));
        access(1'b0, 32'h44, 32'h0, -1, 0, -1, lat, rd);
        check("hit_latency", lat, 32'd1);
        check("hit_data", rd, mem_rd(32'h44));
        access(1'b1, 32'h48, 32'hDEAD_BEEF, -1, 0, -1, lat, rd);
        check("store_hit_latency", lat, 32'd1);
        access(1'b0, 32'h48, 32'h0, -1, 0, -1, lat, rd);
        check("store_readback", rd, 32'hDEAD_BEEF);
        access(1'b0, 32'h248, 32'h0, -1, 0, -1, lat, rd);
        check("dirty_miss_latency", lat, 32'd18);
        check("dirty_miss_data", rd, mem_rd(32'h248));
        check("writeback_word", mem_wr[32'h48], 32'hDEAD_BEEF);

        access(1'b0, 32'h80, 32'h0, 4, 5, -1, lat, rd);
        check("held_refill_latency", lat, 32'd15);

        access(1'b0, 32'hC0, 32'h0, -1, 0, 3, lat, rd);
        access(1'b0, 32'h40, 32'h0, -1, 0, -1, lat, rd);
        check("post_reset_miss_latency", lat, 32'd10);

        access(1'b1, 32'h1C, 32'h1234_5678, -1, 0, -1, lat, rd);
        access(1'b1, 32'h41C, 32'hCAFE_F00D, -1, 0, -1, lat, rd);
        check("evict_dirty_latency", lat, 32'd18);
        access(1'b0, 32'h1C, 32'h0, -1, 0, -1, lat, rd);
        check("refetch_written_back", rd, 32'h1234_5678);
        access(1'b0, 32'h41C, 32'h0, -1, 0, -1, lat, rd);
        check("refetch_second_line", rd, 32'hCAFE_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
